// File: rtl/audio_record_sequencer.sv
// Record/playback sequencer around an on-chip single-port sample buffer.
// Records MicData on SampleTick, replays the captured length to the DAC interface.
module audio_record_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              StartRecord,
  input  logic              StartPlay,
  input  logic              Stop,
  input  logic              SampleTick,
  input  logic [DATA_W-1:0] MicData,
  output logic [DATA_W-1:0] SpkData,
  output logic              SpkValid,
  output logic              Recording,
  output logic              Playing,
  output logic              BufFull,
  output logic [ADDR_W:0]   RecLength
);

  localparam int             DEPTH_N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     len_inc;
  logic                valid_q, valid_d;
  logic                have_q, have_d;
  logic                wr_en, rd_en;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   mem [DEPTH_N];

  assign len_inc = len_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    valid_d = 1'b0;
    have_d  = have_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartRecord) begin
          state_d = S_RECORD;
          addr_d  = '0;
          len_d   = '0;
        end else if (StartPlay && len_q != '0) begin
          state_d = S_PLAY;
          addr_d  = '0;
        end
      end
      S_RECORD: begin
        if (SampleTick) begin
          wr_en = 1'b1;
          len_d = len_inc;
          // address is held on the final write so it never wraps
          if (len_inc == DEPTH) state_d = S_IDLE;
          else                  addr_d  = addr_q + 1'b1;
        end
        if (Stop) state_d = S_IDLE;
      end
      S_PLAY: begin
        if (SampleTick) begin
          rd_en   = 1'b1;
          valid_d = 1'b1;
          have_d  = 1'b1;
          if ({1'b0, addr_q} == len_q - 1'b1) state_d = S_IDLE;
          else                                 addr_d  = addr_q + 1'b1;
        end
        if (Stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      have_q  <= have_d;
    end
  end

  // Buffer is not reset; have_q masks the stale read register to zero after reset.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[addr_q] <= MicData;
    if (rd_en) rd_data_q   <= mem[addr_q];
  end

  assign SpkData   = have_q ? rd_data_q : '0;
  assign SpkValid  = valid_q;
  assign Recording = (state_q == S_RECORD);
  assign Playing   = (state_q == S_PLAY);
  assign BufFull   = (len_q == DEPTH);
  assign RecLength = len_q;

endmodule
